// File: rtl/z16_ctrl_pkg.sv
// z16_ctrl_pkg: shared state encoding, opcode constants and opcode-class decode
// for the Z16 multi-cycle sequencer.
package z16_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_HALT   = 3'd4
  } op_class_t;

  localparam logic [3:0] OP_LOAD     = 4'h9;
  localparam logic [3:0] OP_LI       = 4'hA;
  localparam logic [3:0] OP_STORE    = 4'hB;
  localparam logic [3:0] OP_BR_FIRST = 4'hC;
  localparam logic [3:0] OP_BR_LAST  = 4'hE;
  localparam logic [3:0] OP_HALT     = 4'hF;

  // LI sits between LOAD and STORE but behaves as an ALU op.
  function automatic op_class_t op_class(input logic [3:0] op);
    if (op == OP_LOAD)
      return CLS_LOAD;
    else if (op == OP_STORE)
      return CLS_STORE;
    else if (op == OP_HALT)
      return CLS_HALT;
    else if (op >= OP_BR_FIRST && op <= OP_BR_LAST)
      return CLS_BRANCH;
    else if (op == OP_LI)
      return CLS_ALU;
    else
      return CLS_ALU;
  endfunction

endpackage

// File: rtl/z16_perf_counter.sv
// z16_perf_counter: 32-bit enabled counter, wraps from 0xFFFFFFFF to 0.
`default_nettype none

module z16_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= 32'd0;
    else if (en)
      count <= count + 32'd1;
  end

endmodule

`default_nettype wire

// File: rtl/z16_multicycle_ctrl.sv
// z16_multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer for the Z16 core.
// Z16_SEQ_PERF_EN builds the retired-instruction and memory-stall counters.
`default_nettype none

module z16_multicycle_ctrl
  import z16_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_opcode,
  input  logic        i_rd_wen,
  input  logic        i_mem_wen,
  input  logic        i_br_taken,
  input  logic        i_resume,
  output logic        o_imem_req,
  input  logic        i_imem_ack,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_ack,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic        o_pc_sel,
  output logic        o_rf_wen,
  output logic        o_rf_wsel,
  output logic        o_halted,
  output logic [2:0]  o_state,
  output logic [31:0] o_retired,
  output logic [31:0] o_stall_cycles
);

  state_t    state;
  logic      started;
  op_class_t cls;

  assign cls     = op_class(i_opcode);
  assign o_state = state;

  // started keeps the fetch request low until the first clock after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_FETCH;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        ST_FETCH:  if (started && i_imem_ack) state <= ST_DECODE;
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC: begin
          case (cls)
            CLS_LOAD, CLS_STORE: state <= ST_MEM;
            CLS_BRANCH:          state <= ST_FETCH;
            CLS_HALT:            state <= ST_HALT;
            default:             state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (i_dmem_ack)
            state <= (cls == CLS_LOAD) ? ST_WB : ST_FETCH;
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: if (i_resume) state <= ST_FETCH;
        default: state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    o_imem_req = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_ir_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_sel   = 1'b0;
    o_rf_wen   = 1'b0;
    o_rf_wsel  = 1'b0;
    o_halted   = 1'b0;
    case (state)
      ST_FETCH: begin
        o_imem_req = started;
        o_ir_we    = started & i_imem_ack;
      end
      ST_EXEC: begin
        if (cls == CLS_BRANCH) begin
          o_pc_we  = 1'b1;
          o_pc_sel = i_br_taken;
        end else if (cls == CLS_HALT) begin
          o_pc_we  = 1'b1;
        end
      end
      ST_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = i_mem_wen;
        o_pc_we    = i_dmem_ack & (cls == CLS_STORE);
      end
      ST_WB: begin
        o_rf_wen  = (cls == CLS_LOAD) ? 1'b1 : i_rd_wen;
        o_rf_wsel = (cls == CLS_LOAD);
        o_pc_we   = 1'b1;
      end
      ST_HALT: o_halted = 1'b1;
      default: ;
    endcase
  end

`ifdef Z16_SEQ_PERF_EN
  // Every retire point coincides with a PC update.
  logic retire;
  logic stall;

  assign retire = o_pc_we;
  assign stall  = (o_imem_req & ~i_imem_ack) | (o_dmem_req & ~i_dmem_ack);

  z16_perf_counter u_retired (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (retire),
    .count (o_retired)
  );

  z16_perf_counter u_stalls (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .en    (stall),
    .count (o_stall_cycles)
  );
`else
  assign o_retired      = 32'd0;
  assign o_stall_cycles = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_z16_multicycle_ctrl.sv
// tb_z16_multicycle_ctrl: directed self-checking bench for z16_multicycle_ctrl.
`default_nettype none

module tb_z16_multicycle_ctrl;

`ifdef Z16_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_opcode;
  logic        i_rd_wen, i_mem_wen, i_br_taken, i_resume;
  logic        o_imem_req, i_imem_ack;
  logic        o_dmem_req, o_dmem_we, i_dmem_ack;
  logic        o_ir_we, o_pc_we, o_pc_sel, o_rf_wen, o_rf_wsel, o_halted;
  logic [2:0]  o_state;
  logic [31:0] o_retired, o_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  z16_multicycle_ctrl dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_opcode       (i_opcode),
    .i_rd_wen       (i_rd_wen),
    .i_mem_wen      (i_mem_wen),
    .i_br_taken     (i_br_taken),
    .i_resume       (i_resume),
    .o_imem_req     (o_imem_req),
    .i_imem_ack     (i_imem_ack),
    .o_dmem_req     (o_dmem_req),
    .o_dmem_we      (o_dmem_we),
    .i_dmem_ack     (i_dmem_ack),
    .o_ir_we        (o_ir_we),
    .o_pc_we        (o_pc_we),
    .o_pc_sel       (o_pc_sel),
    .o_rf_wen       (o_rf_wen),
    .o_rf_wsel      (o_rf_wsel),
    .o_halted       (o_halted),
    .o_state        (o_state),
    .o_retired      (o_retired),
    .o_stall_cycles (o_stall_cycles)
  );

  initial forever #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] pexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  int   req_cnt;
  logic seen;
  logic halted_all;

  initial begin
    i_rst_n = 1'b0; i_opcode = 4'h0; i_rd_wen = 1'b0; i_mem_wen = 1'b0;
    i_br_taken = 1'b0; i_resume = 1'b0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0;

    // Reset state
    #2;
    chk("rst_state",   {29'd0, o_state}, 32'd0);
    chk("rst_imem",    {31'd0, o_imem_req}, 32'd0);
    chk("rst_pc_we",   {31'd0, o_pc_we}, 32'd0);
    chk("rst_halted",  {31'd0, o_halted}, 32'd0);
    chk("rst_retired", o_retired, 32'd0);
    chk("rst_stall",   o_stall_cycles, 32'd0);

    // Release reset; ack while request still low must be ignored
    tick();
    i_rst_n = 1'b1; i_imem_ack = 1'b1; i_opcode = 4'h3; i_rd_wen = 1'b1;
    #1;
    chk("post_rel_imem", {31'd0, o_imem_req}, 32'd0);

    // ALU 0x3, 0-wait fetch
    tick();
    chk("alu_f_state", {29'd0, o_state}, 32'd0);
    chk("alu_f_req",   {31'd0, o_imem_req}, 32'd1);
    chk("alu_f_irwe",  {31'd0, o_ir_we}, 32'd1);
    i_resume = 1'b1;
    tick();
    chk("alu_d_state", {29'd0, o_state}, 32'd1);
    chk("alu_d_irwe",  {31'd0, o_ir_we}, 32'd0);
    tick();
    chk("resume_ignored", {29'd0, o_state}, 32'd2);
    chk("alu_e_pcwe",  {31'd0, o_pc_we}, 32'd0);
    chk("alu_e_rfwen", {31'd0, o_rf_wen}, 32'd0);
    i_resume = 1'b0;
    tick();
    chk("alu_wb_state", {29'd0, o_state}, 32'd4);
    chk("alu_wb_rfwen", {31'd0, o_rf_wen}, 32'd1);
    chk("alu_wb_wsel",  {31'd0, o_rf_wsel}, 32'd0);
    chk("alu_wb_pcwe",  {31'd0, o_pc_we}, 32'd1);
    chk("alu_wb_pcsel", {31'd0, o_pc_sel}, 32'd0);
    tick();
    chk("alu_done_state", {29'd0, o_state}, 32'd0);
    chk("alu_retired",    o_retired, pexp(1));
    chk("alu_stall",      o_stall_cycles, pexp(0));

    // LOAD 0x9, dmem ack after 3 wait cycles
    i_opcode = 4'h9; i_mem_wen = 1'b0; i_dmem_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("ld_mem_state", {29'd0, o_state}, 32'd3);
    req_cnt = 0; seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (o_dmem_req) req_cnt++;
      seen = seen | o_dmem_we;
      tick();
    end
    i_dmem_ack = 1'b1;
    #1;
    if (o_dmem_req) req_cnt++;
    seen = seen | o_dmem_we;
    chk("ld_pcwe_in_mem", {31'd0, o_pc_we}, 32'd0);
    tick();
    i_dmem_ack = 1'b0;
    chk("ld_req_cycles", 32'(req_cnt), 32'd4);
    chk("ld_we_seen",    {31'd0, seen}, 32'd0);
    chk("ld_wb_state",   {29'd0, o_state}, 32'd4);
    chk("ld_wb_rfwen",   {31'd0, o_rf_wen}, 32'd1);
    chk("ld_wb_wsel",    {31'd0, o_rf_wsel}, 32'd1);
    chk("ld_wb_pcwe",    {31'd0, o_pc_we}, 32'd1);
    chk("ld_stall",      o_stall_cycles, pexp(3));
    tick();
    chk("ld_done_state", {29'd0, o_state}, 32'd0);
    chk("ld_retired",    o_retired, pexp(2));

    // STORE 0xB, 0-wait dmem
    i_opcode = 4'hB; i_mem_wen = 1'b1; i_rd_wen = 1'b0; i_dmem_ack = 1'b1;
    seen = o_rf_wen;
    tick(); seen = seen | o_rf_wen;
    tick(); seen = seen | o_rf_wen;
    tick(); seen = seen | o_rf_wen;
    chk("st_mem_state", {29'd0, o_state}, 32'd3);
    chk("st_req",       {31'd0, o_dmem_req}, 32'd1);
    chk("st_we",        {31'd0, o_dmem_we}, 32'd1);
    chk("st_pcwe",      {31'd0, o_pc_we}, 32'd1);
    chk("st_pcsel",     {31'd0, o_pc_sel}, 32'd0);
    tick();
    chk("st_no_rfwen",  {31'd0, seen}, 32'd0);
    chk("st_4cyc_state", {29'd0, o_state}, 32'd0);
    chk("st_retired",   o_retired, pexp(3));

    // BRANCH 0xD taken, then 0xC not taken
    i_opcode = 4'hD; i_br_taken = 1'b1; i_mem_wen = 1'b0; i_dmem_ack = 1'b0;
    tick();
    tick();
    chk("brt_state", {29'd0, o_state}, 32'd2);
    chk("brt_pcwe",  {31'd0, o_pc_we}, 32'd1);
    chk("brt_pcsel", {31'd0, o_pc_sel}, 32'd1);
    tick();
    chk("brt_done",  {29'd0, o_state}, 32'd0);
    i_opcode = 4'hC; i_br_taken = 1'b0;
    tick();
    tick();
    chk("brn_pcwe",  {31'd0, o_pc_we}, 32'd1);
    chk("brn_pcsel", {31'd0, o_pc_sel}, 32'd0);
    tick();
    chk("brn_done",    {29'd0, o_state}, 32'd0);
    chk("br_retired",  o_retired, pexp(5));

    // HALT 0xF, sit for 10 cycles, then resume
    i_opcode = 4'hF;
    tick();
    tick();
    chk("hlt_e_pcwe",  {31'd0, o_pc_we}, 32'd1);
    chk("hlt_e_pcsel", {31'd0, o_pc_sel}, 32'd0);
    tick();
    chk("hlt_state", {29'd0, o_state}, 32'd5);
    seen = 1'b0; halted_all = 1'b1;
    for (int i = 0; i < 10; i++) begin
      seen = seen | o_imem_req | o_dmem_req;
      halted_all = halted_all & o_halted;
      tick();
    end
    chk("hlt_no_req",  {31'd0, seen}, 32'd0);
    chk("hlt_halted",  {31'd0, halted_all}, 32'd1);
    chk("hlt_retired", o_retired, pexp(6));
    i_resume = 1'b1;
    tick();
    i_resume = 1'b0;
    chk("resume_state", {29'd0, o_state}, 32'd0);
    chk("resume_imem",  {31'd0, o_imem_req}, 32'd1);

    // Reset asserted during MEM of a STORE
    i_opcode = 4'hB; i_mem_wen = 1'b1; i_dmem_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmem_req", {31'd0, o_dmem_req}, 32'd1);
    chk("rstmem_we",  {31'd0, o_dmem_we}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("rstmem_req_drop", {31'd0, o_dmem_req}, 32'd0);
    chk("rstmem_we_drop",  {31'd0, o_dmem_we}, 32'd0);
    chk("rstmem_state",    {29'd0, o_state}, 32'd0);
    chk("rstmem_retired",  o_retired, 32'd0);
    chk("rstmem_stall",    o_stall_cycles, 32'd0);
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("rstrel_imem", {31'd0, o_imem_req}, 32'd0);
    tick();
    chk("rstrel_state",   {29'd0, o_state}, 32'd0);
    chk("rstrel_imem_up", {31'd0, o_imem_req}, 32'd1);
    chk("rstrel_dmem",    {31'd0, o_dmem_req}, 32'd0);
    chk("rstrel_retired", o_retired, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/z16_multicycle_ctrl.md
# z16_multicycle_ctrl

Multi-cycle sequencer for the Z16 core. It drives instruction fetch, instruction-register capture, execute, data-memory access and register writeback around the Z16 instruction decoder. It consumes the decoder's opcode, register-write-enable and memory-write-enable fields. It produces every enable and handshake strobe the PC, instruction register, register file and memory ports need.

## Interface
- No parameters.
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_opcode  in  4  decoder opecode field (instr[3:0])
- i_rd_wen  in  1  decoder register-write enable
- i_mem_wen  in  1  decoder memory-write enable
- i_br_taken  in  1  branch condition from datapath, sampled in EXEC
- i_resume  in  1  leave HALT
- o_imem_req  out  1  instruction fetch request
- i_imem_ack  in  1  fetch complete; instruction data is valid this cycle
- o_dmem_req  out  1  data memory request
- o_dmem_we  out  1  data memory write (valid with o_dmem_req)
- i_dmem_ack  in  1  data access complete; read data is valid this cycle
- o_ir_we  out  1  capture instruction into the instruction register
- o_pc_we  out  1  update PC
- o_pc_sel  out  1  0 = PC+1, 1 = branch target
- o_rf_wen  out  1  register-file write strobe
- o_rf_wsel  out  1  0 = ALU/immediate result, 1 = memory read data
- o_halted  out  1  core is in HALT
- o_state  out  3  current state encoding
- o_retired  out  32  retired-instruction count (see Configuration)
- o_stall_cycles  out  32  memory-wait cycle count (see Configuration)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6–7 are unreachable and go to FETCH.
- Opcode classes:
  - ALU = 0x0–0x8 and 0xA
  - LOAD = 0x9
  - STORE = 0xB
  - BRANCH = 0xC–0xE
  - HALT = 0xF
- FETCH:
  - o_imem_req=1.
  - On i_imem_ack: o_ir_we=1 for that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle. The decoder outputs are settled; go to EXEC.
- EXEC:
  - ALU: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: o_pc_we=1, o_pc_sel=i_br_taken, go to FETCH. The branch retires here.
  - HALT: o_pc_we=1, o_pc_sel=0, go to HALT. The halt retires here.
- MEM:
  - o_dmem_req=1, o_dmem_we=i_mem_wen.
  - On i_dmem_ack: LOAD goes to WB; STORE asserts o_pc_we=1, o_pc_sel=0, retires, and goes to FETCH.
- WB:
  - o_rf_wen = i_rd_wen for ALU; o_rf_wen = 1 for LOAD.
  - o_rf_wsel = 1 for LOAD, 0 otherwise.
  - o_pc_we=1, o_pc_sel=0, retire, go to FETCH.
- HALT:
  - o_halted=1; no requests are issued.
  - i_resume=1 goes to FETCH next cycle.
- All strobes not listed for a state are 0. o_pc_sel is 0 whenever o_pc_we=0.

## Timing
- Reset (async assert, sync deassert in the surrounding logic):
  - state=FETCH, counters=0, all strobes=0.
  - o_imem_req rises on the first clock after i_rst_n releases.
  - Outputs are Moore/registered-state decoded, so requests drop combinationally on reset assertion.
- Handshakes:
  - A request is held high until its ack.
  - An ack in the same cycle the request is first asserted is accepted (0-wait).
  - An ack while the request is low is ignored.
  - The requester does not change o_dmem_we while waiting.
- Latency with 0-wait memory:
  - ALU: 4 cycles.
  - BRANCH, HALT: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- Reset mid-MEM aborts the access; no write strobe is reissued after reset.
- i_resume asserted outside HALT is ignored.

## Configuration
- Z16_SEQ_PERF_EN defined:
  - o_retired increments by 1 on each retire cycle.
  - o_stall_cycles increments on every cycle a request is high without an ack.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built. Ports are always present.

## Structure
- Package z16_ctrl_pkg:
  - state enum (3-bit)
  - opcode constants OP_LOAD=4'h9, OP_LI=4'hA, OP_STORE=4'hB, OP_BR_FIRST=4'hC, OP_BR_LAST=4'hE, OP_HALT=4'hF
  - class-decode function
- Sub-module z16_perf_counter: one 32-bit enabled wrapping counter, instantiated twice under the macro.

## Test plan
- ALU op 0x3 with i_rd_wen=1 and 0-wait imem -> states 0,1,2,4; o_rf_wen=1 exactly in cycle 4 with o_rf_wsel=0; o_pc_we once with o_pc_sel=0.
- LOAD 0x9, dmem ack delayed 3 cycles -> o_dmem_req high 4 cycles with o_dmem_we=0, then WB with o_rf_wsel=1; o_stall_cycles=3 (macro on).
- STORE 0xB with i_mem_wen=1 -> o_dmem_we=1 throughout MEM; no o_rf_wen; 4 cycles total.
- BRANCH 0xD with i_br_taken=1, then 0xC with i_br_taken=0 -> o_pc_sel=1, then o_pc_sel=0; each takes 3 cycles.
- HALT 0xF -> o_halted=1 and no requests for 10 cycles; i_resume pulse -> FETCH next cycle; o_retired counts the halt.
- i_rst_n low during MEM of a STORE -> o_dmem_req drops immediately; after release o_state=0 and o_retired=0.
